// File: rtl/pvtmon_drp_poller_if.sv
// DRP port bundle between the PVT monitor poller (master) and the DRP block (slave).
interface pvtmon_drp_poller_if;
  logic        drp_den;
  logic        drp_dwe;
  logic [7:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (
    output drp_den,
    output drp_dwe,
    output drp_daddr,
    output drp_di,
    input  drp_do,
    input  drp_drdy
  );

  modport slave (
    input  drp_den,
    input  drp_dwe,
    input  drp_daddr,
    input  drp_di,
    output drp_do,
    output drp_drdy
  );
endinterface

// File: rtl/pvtmon_drp_poller.sv
// Periodically sweeps a list of DRP addresses, one read at a time, and keeps a packed
// status word per channel (last data, address, timeout flag, valid flag).
module pvtmon_drp_poller #(
  parameter int unsigned                    NUM_POWER_REG = 13,
  parameter logic [NUM_POWER_REG*8-1:0]     ADDR_LIST     = '0,
  parameter int unsigned                    POLL_INTERVAL = 1000000,
  parameter int unsigned                    TIMEOUT       = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  pvtmon_drp_poller_if.master           drp,
  output logic [NUM_POWER_REG*32-1:0]   power_status,
  output logic                          sweep_done,
  output logic [15:0]                   timeout_count
);

  localparam int unsigned IdxW = (NUM_POWER_REG > 1) ? $clog2(NUM_POWER_REG) : 1;
  localparam int unsigned CntW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IdxW-1:0] LastIdx      = IdxW'(NUM_POWER_REG - 1);
  localparam logic [CntW-1:0] IntervalLoad = CntW'(POLL_INTERVAL - 1);
  localparam logic [ToW-1:0]  ToLast       = ToW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [CntW-1:0]                ivl_q, ivl_d;
  logic [ToW-1:0]                 to_q, to_d;
  logic                           den_q, den_d;
  logic [7:0]                     daddr_q, daddr_d;
  logic                           done_q, done_d;
  logic [15:0]                    tcnt_q, tcnt_d;
  logic [NUM_POWER_REG-1:0][15:0] data_q, data_d;
  logic [NUM_POWER_REG-1:0]       tout_q, tout_d;
  logic [NUM_POWER_REG-1:0]       good_q, good_d;
  logic                           advance;
  logic [7:0]                     next_addr;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ivl_d   = ivl_q;
    to_d    = to_q;
    done_d  = 1'b0;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    tout_d  = tout_q;
    good_d  = good_q;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ivl_q != '0) begin
          ivl_d = ivl_q - CntW'(1);
        end else if (enable) begin
          state_d = StIssue;
          idx_d   = '0;
        end
      end
      StIssue: begin
        to_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // A drdy on the final allowed cycle still counts as a good read.
        if (drp.drp_drdy) begin
          for (int i = 0; i < NUM_POWER_REG; i++) begin
            if (idx_q == IdxW'(i)) begin
              data_d[i] = drp.drp_do;
              tout_d[i] = 1'b0;
              good_d[i] = 1'b1;
            end
          end
          advance = 1'b1;
        end else if (to_q == ToLast) begin
          for (int i = 0; i < NUM_POWER_REG; i++) begin
            if (idx_q == IdxW'(i)) tout_d[i] = 1'b1;
          end
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          advance = 1'b1;
        end else begin
          to_d = to_q + ToW'(1);
        end

        if (advance) begin
          if (idx_q != LastIdx) begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StIssue;
          end else begin
            done_d  = 1'b1;
            ivl_d   = IntervalLoad;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    next_addr = 8'h00;
    for (int i = 0; i < NUM_POWER_REG; i++) begin
      if (idx_d == IdxW'(i)) next_addr = ADDR_LIST[i*8 +: 8];
    end
  end

  // den/daddr are registered so they are clean one-cycle pulses aligned with the ISSUE state.
  always_comb begin
    den_d   = (state_d == StIssue);
    daddr_d = (state_d == StIssue) ? next_addr : daddr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ivl_q   <= '0;
      to_q    <= '0;
      den_q   <= 1'b0;
      daddr_q <= 8'h00;
      done_q  <= 1'b0;
      tcnt_q  <= 16'h0000;
      data_q  <= '0;
      tout_q  <= '0;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ivl_q   <= ivl_d;
      to_q    <= to_d;
      den_q   <= den_d;
      daddr_q <= daddr_d;
      done_q  <= done_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    power_status = '0;
    for (int i = 0; i < NUM_POWER_REG; i++) begin
      power_status[i*32 +: 32] = {good_q[i], tout_q[i], 6'b0, ADDR_LIST[i*8 +: 8], data_q[i]};
    end
  end

  assign drp.drp_den   = den_q;
  assign drp.drp_dwe   = 1'b0;
  assign drp.drp_daddr = daddr_q;
  assign drp.drp_di    = 16'h0000;
  assign sweep_done    = done_q;
  assign timeout_count = tcnt_q;

endmodule

// File: doc/pvtmon_drp_poller.md
PVTMON_DRP_POLLER -- requirements
Module: pvtmon_drp_poller

Interface
REQ-001 Parameter NUM_POWER_REG, default 13: number of monitored channels and 32-bit status words.
REQ-002 Parameter ADDR_LIST, default 0, NUM_POWER_REG*8 bits: DRP address of channel i is ADDR_LIST[i*8+:8].
REQ-003 Parameter POLL_INTERVAL, default 1000000, minimum 1: idle clk cycles between the end of one sweep and the start of the next.
REQ-004 Parameter TIMEOUT, default 255, minimum 1: maximum clk cycles to wait for drp_drdy per read.
REQ-005 clk  input  1  sole clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  high allows a new sweep to start; a sweep in progress always completes.
REQ-008 drp_den  output  1  DRP enable, one-cycle pulse per read.
REQ-009 drp_dwe  output  1  DRP write enable, constant 0.
REQ-010 drp_daddr  output  8  DRP address of the current read.
REQ-011 drp_di  output  16  DRP write data, constant 0.
REQ-012 drp_do  input  16  DRP read data, qualified by drp_drdy.
REQ-013 drp_drdy  input  1  DRP read-data-ready pulse.
REQ-014 power_status  output  NUM_POWER_REG*32  packed status words, word i at [i*32+:32], consumed by the pvtmon AXI-lite register slave.
REQ-015 sweep_done  output  1  one-cycle pulse when the last channel of a sweep is finished.
REQ-016 timeout_count  output  16  saturating count of DRP read timeouts since reset.

Function
REQ-017 Status word format: [15:0] last good drp_do; [23:16] channel DRP address; [29:24] 0; [30] last read of this channel timed out; [31] at least one good read since reset.
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-019 IDLE: the interval counter SHALL decrement if nonzero; when it is 0 and enable=1, the FSM SHALL go to ISSUE with channel index 0; when enable=0, the counter SHALL hold at 0.
REQ-020 ISSUE: drp_den=1 and drp_daddr=ADDR_LIST[idx*8+:8] for exactly this one cycle; the timeout counter SHALL clear; next state is WAIT.
REQ-021 drp_daddr SHALL hold its value from ISSUE until the next ISSUE.
REQ-022 WAIT, drp_drdy=1: word idx SHALL load bits [15:0]=drp_do, [30]=0, [31]=1 on that edge, so power_status is visible 1 cycle after drdy.
REQ-023 WAIT, no drdy after TIMEOUT cycles: word idx SHALL set [30]=1 and keep [15:0] and [31]; timeout_count SHALL increment, saturating at 16'hFFFF.
REQ-024 If drp_drdy and timeout coincide in the same cycle, drdy SHALL win and no timeout is recorded.
REQ-025 Channel advance after WAIT: if idx < NUM_POWER_REG-1, then idx increments and the next state is ISSUE; otherwise sweep_done=1 for one cycle, the interval counter loads POLL_INTERVAL-1, and the next state is IDLE.
REQ-026 drp_drdy in IDLE or ISSUE SHALL be ignored, with no state or data change.
REQ-027 Bits [23:16] of each word SHALL always equal that channel's ADDR_LIST entry, including during reset.
REQ-028 Exactly one DRP read SHALL be outstanding at a time; drp_den SHALL never assert in WAIT or IDLE.

Reset
REQ-029 On reset=1, the FSM SHALL go to IDLE with idx=0 and interval counter=0.
REQ-030 On reset=1, drp_den=0, drp_daddr=0, sweep_done=0 and timeout_count=0.
REQ-031 On reset=1, every power_status word SHALL be {8'h00, ADDR_LIST entry, 16'h0000}.
REQ-032 Reset SHALL take priority over all events, including mid-sweep and a coincident drdy.
REQ-033 A drdy arriving after reset from a pre-reset read SHALL be ignored per REQ-026.

Verification
REQ-034 NUM_POWER_REG=3, ADDR_LIST={8'h02,8'h01,8'h00}, enable=1, DRP model returns 16'hA000+addr with drdy 2 cycles after den -> den at addrs 00,01,02; words 0x8000A000, 0x8001A001, 0x8002A002; sweep_done pulse once.
REQ-035 POLL_INTERVAL=10 -> exactly 10 IDLE cycles between sweep_done and the next drp_den.
REQ-036 Model never drives drdy for addr 01, TIMEOUT=4 -> word1 bit30=1 and bit31=0, timeout_count=1 after sweep 1; later good read -> bit30=0, bit31=1.
REQ-037 drdy issued exactly on the TIMEOUT-th WAIT cycle -> data stored, timeout_count unchanged.
REQ-038 Reset asserted in WAIT of channel 1, late drdy after release -> all words at reset value, first den to addr 00.
REQ-039 enable dropped mid-sweep -> sweep completes and no further den until enable=1; spurious drdy in IDLE -> no change.
